// File: rtl/calc_result_tx.sv
// Framed serial transmitter for the calculator result: start, sign, result LSB-first,
// even parity over the payload, stop. Each bit is held clks_per_bit cycles.
module calc_result_tx #(
  parameter int unsigned width        = 8,
  parameter int unsigned clks_per_bit = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               send_i,
  input  logic [2*width-1:0] s_i,
  input  logic               signal_i,
  output logic               ready_o,
  output logic               tx_o,
  output logic               done_o
);

  localparam int unsigned PW = 2 * width + 1;
  localparam int unsigned CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int unsigned BW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(clks_per_bit - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PW - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    cyc_d     = (state_q == IDLE || bit_end) ? '0 : cyc_q + CW'(1);

    // tx_d is loaded with the next bit on the edge that ends the current one,
    // so the line value is always a registered output.
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (send_i) begin
          shift_d   = {s_i, signal_i};
          parity_d  = ^{s_i, signal_i};
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          tx_d      = 1'b1;
          ready_d   = 1'b1;
          done_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_q     <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_q     <= cyc_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_calc_result_tx.sv
// Bench for calc_result_tx: directed vector table plus random frames on two
// instances (4 cycles/bit and 1 cycle/bit), checked against a frame-list model.
module tb_calc_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        send4, sig4, send1, sig1;
  logic [15:0] s4, s1;
  logic        tx4, rdy4, done4, tx1, rdy1, done1;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  calc_result_tx #(.width(8), .clks_per_bit(4)) dut4 (
    .clock_i(clk), .reset_i(rst), .send_i(send4), .s_i(s4), .signal_i(sig4),
    .ready_o(rdy4), .tx_o(tx4), .done_o(done4)
  );

  calc_result_tx #(.width(8), .clks_per_bit(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .send_i(send1), .s_i(s1), .signal_i(sig1),
    .ready_o(rdy1), .tx_o(tx1), .done_o(done1)
  );

  typedef struct {
    string       name;
    int          cpb;
    logic [15:0] s;
    logic        sig;
    logic        par;
    int          busy_k;
    int          rst_k;
    int          gap;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic drive(input int cpb, input logic snd, input logic [15:0] s, input logic sig);
    if (cpb == 1) begin
      send1 = snd; s1 = s; sig1 = sig;
    end else begin
      send4 = snd; s4 = s; sig4 = sig;
    end
  endtask

  function automatic logic get_tx(input int cpb);
    return (cpb == 1) ? tx1 : tx4;
  endfunction
  function automatic logic get_rdy(input int cpb);
    return (cpb == 1) ? rdy1 : rdy4;
  endfunction
  function automatic logic get_done(input int cpb);
    return (cpb == 1) ? done1 : done4;
  endfunction

  task automatic chk_idle(input int cpb, input string tag);
    chk({tag, "_idle_tx"}, get_tx(cpb), 1'b1);
    chk({tag, "_idle_rdy"}, get_rdy(cpb), 1'b1);
    chk({tag, "_idle_done"}, get_done(cpb), 1'b0);
  endtask

  // Sends one frame and checks every cycle up to the done cycle. Returns while
  // the bench sits in the done cycle so the next call can send back-to-back.
  task automatic expect_frame(input int cpb, input logic [15:0] s, input logic sig,
                              input logic par, input int busy_k, input int rst_k,
                              input string tag);
    logic fr [20];
    int   last;
    fr[0] = 1'b0;
    fr[1] = sig;
    for (int i = 0; i < 16; i++) fr[2+i] = s[i];
    fr[18] = par;
    fr[19] = 1'b1;
    last = 20 * cpb;

    chk({tag, "_rdy_before"}, get_rdy(cpb), 1'b1);
    drive(cpb, 1'b1, s, sig);
    tick();
    for (int k = 0; k <= last; k++) begin
      drive(cpb, 1'b0, 16'($urandom), 1'($urandom));
      if (k < last) begin
        chk($sformatf("%s_tx_k%0d", tag, k), get_tx(cpb), fr[k / cpb]);
        chk($sformatf("%s_rdy_k%0d", tag, k), get_rdy(cpb), 1'b0);
        chk($sformatf("%s_done_k%0d", tag, k), get_done(cpb), 1'b0);
      end else begin
        chk({tag, "_end_tx"}, get_tx(cpb), 1'b1);
        chk({tag, "_end_rdy"}, get_rdy(cpb), 1'b1);
        chk({tag, "_end_done"}, get_done(cpb), 1'b1);
      end
      if (k == busy_k) drive(cpb, 1'b1, 16'h1234, 1'b1);
      if (k == rst_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle(cpb, {tag, "_rst"});
        tick();
        chk_idle(cpb, {tag, "_rst_after"});
        return;
      end
      if (k < last) tick();
    end
  endtask

  vec_t tbl [8];

  initial begin
    logic [15:0] rs;
    logic        rsig;
    int          cpb, busy;

    tbl[0] = '{"basic",  4, 16'h00A5, 1'b0, 1'b0, -1, -1, 1};
    tbl[1] = '{"odd",    4, 16'hFFFF, 1'b1, 1'b1, -1, -1, 2};
    tbl[2] = '{"busy",   4, 16'h00A5, 1'b0, 1'b0, 30, -1, 1};
    tbl[3] = '{"b2b_a",  4, 16'h0001, 1'b0, 1'b1, -1, -1, 0};
    tbl[4] = '{"b2b_b",  4, 16'h8000, 1'b0, 1'b1, -1, -1, 1};
    tbl[5] = '{"rstmid", 4, 16'h00A5, 1'b0, 1'b0, -1, 40, 0};
    tbl[6] = '{"postrst",4, 16'h00A5, 1'b0, 1'b0, -1, -1, 1};
    tbl[7] = '{"cpb1",   1, 16'h00A5, 1'b0, 1'b0, -1, -1, 1};

    rst = 1'b1;
    drive(4, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    tick();
    tick();
    chk_idle(4, "reset4");
    chk_idle(1, "reset1");
    rst = 1'b0;
    tick();
    chk_idle(4, "post_reset4");

    // Reset wins over a same-edge send.
    drive(4, 1'b1, 16'h00A5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4, 1'b0, '0, 1'b0);
    chk_idle(4, "rst_vs_send");
    tick();
    chk_idle(4, "rst_vs_send_after");

    foreach (tbl[i]) begin
      expect_frame(tbl[i].cpb, tbl[i].s, tbl[i].sig, tbl[i].par,
                   tbl[i].busy_k, tbl[i].rst_k, tbl[i].name);
      for (int g = 0; g < tbl[i].gap; g++) begin
        tick();
        chk_idle(tbl[i].cpb, $sformatf("%s_gap%0d", tbl[i].name, g));
      end
    end

    for (int n = 0; n < 40; n++) begin
      cpb  = (n % 2 == 1) ? 1 : 4;
      rs   = 16'($urandom);
      rsig = 1'($urandom);
      busy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20 * cpb - 1)) : -1;
      expect_frame(cpb, rs, rsig, 1'($countones({rs, rsig}) % 2), busy, -1,
                   $sformatf("rnd%0d", n));
      for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
        tick();
        chk_idle(cpb, $sformatf("rnd%0d_gap%0d", n, g));
      end
    end

    // Random back-to-back pair on the 1-cycle-per-bit instance.
    rs = 16'($urandom);
    expect_frame(1, rs, 1'b1, 1'(($countones(rs) + 1) % 2), -1, -1, "b2b1_a");
    rs = 16'($urandom);
    expect_frame(1, rs, 1'b0, 1'($countones(rs) % 2), -1, -1, "b2b1_b");
    tick();
    chk_idle(1, "b2b1_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_result_tx.md
Name: calc_result_tx

Overview:
Serial transmitter for the calculator's registered result.
- Captures the 2*width-bit result and the sign/status flag on a one-cycle send request.
- Shifts them out on a single line as a framed, parity-protected word: start bit, payload, parity, stop.
- Sits downstream of the calculator top level's result and signal registers; it is the outbound end of the result link.

Parameters:
width, 8, operand width of the calculator; result payload is 2*width bits
clks_per_bit, 4, clock cycles each serial bit is held on tx_o; legal range is 1 or greater

Ports:
clock_i  input  1  single system clock, rising edge
reset_i  input  1  reset, synchronous, active-high
send_i  input  1  request to transmit; sampled only while ready_o=1
s_i  input  2*width  result word to transmit
signal_i  input  1  sign/status flag to transmit
ready_o  output  1  high when idle and able to accept send_i
tx_o  output  1  serial line; idles high
done_o  output  1  one-cycle pulse when a frame has fully completed

Behaviour:
- Reset and clocking:
  - One clock (clock_i). reset_i is synchronous and active-high; all state updates on the rising edge of clock_i only.
  - Reset values: tx_o=1, ready_o=1, done_o=0, state=IDLE, bit and cycle counters=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_o=1, ready_o=1.
  - An edge with send_i=1 captures {s_i, signal_i} into the shift register.
  - The same edge computes parity = XOR of signal_i and all s_i bits (even parity over payload).
  - The FSM moves to START. tx_o=0 and ready_o=0 from that edge.
- Frame order on tx_o:
  - start (0)
  - signal_i
  - s_i[0] .. s_i[2*width-1], LSB first
  - parity
  - stop (1)
- Frame length is 2*width+4 bits.
- Bit timing:
  - Each bit is held exactly clks_per_bit cycles, timed by a cycle counter of clog2(clks_per_bit) bits, minimum 1.
  - A bit counter tracks the payload position. DATA covers 2*width+1 payload bits, sign included.
- Transitions:
  - Each transition occurs when the cycle counter reaches clks_per_bit-1. Sequence: START -> DATA -> PARITY -> STOP -> IDLE.
  - DATA stays until the last payload bit completes.
- Completion:
  - Exactly (2*width+4)*clks_per_bit cycles after the accepting edge, the FSM is in IDLE: ready_o=1 and done_o=1 for one cycle.
  - done_o is registered, never combinational.
- Back-to-back:
  - send_i=1 during the done_o cycle is accepted at the next edge.
  - There are no idle-high gap cycles beyond the stop bit.
- send_i while ready_o=0 is ignored: not queued, no effect on the current frame.
- s_i and signal_i may change freely after acceptance; the transmitted frame uses the captured values only.
- Reset mid-frame aborts the frame: tx_o=1, ready_o=1 after that edge, and no done_o pulse.
- Reset has priority over send_i on the same edge.
- clks_per_bit=1 is fully supported: one cycle per bit, and a frame takes 2*width+4 cycles.

Test Plan:
- Basic frame (width=8, clks_per_bit=4):
  - Stimulus: s_i=16'h00A5, signal_i=0, send pulse.
  - Required tx_o bit sequence: 0, 0, 1,0,1,0,0,1,0,1, eight 0s, parity 0, 1.
  - Each bit lasts 4 cycles; done_o pulses and ready_o=1 exactly 80 cycles after the accepting edge.
- Odd parity payload:
  - Stimulus: s_i=16'hFFFF, signal_i=1.
  - Required: payload is seventeen 1s, parity bit=1, stop=1, done_o after 80 cycles.
- Busy ignore:
  - Stimulus: second send_i with s_i=16'h1234 issued at cycle 30 of a frame carrying 16'h00A5.
  - Required: frame unchanged, only one done_o pulse, ready_o stays 0 until cycle 80.
- Back-to-back:
  - Stimulus: send_i held high in the done_o cycle, with 16'h0001 then 16'h8000.
  - Required: second start bit begins on the next edge; frames are contiguous; two done_o pulses 80 cycles apart.
- Reset mid-frame:
  - Stimulus: reset_i=1 for 1 cycle at cycle 40.
  - Required: tx_o=1, ready_o=1 next cycle, and no done_o.
  - Follow-up: a subsequent send of 16'h00A5 yields a correct 80-cycle frame.
- clks_per_bit=1:
  - Stimulus: s_i=16'h00A5, signal_i=0.
  - Required: same bit sequence at 1 cycle/bit, done_o after 20 cycles.
